sync_ptr_r2: RTL and testbench
==============================

Name: sync_ptr_r2

Overview:
- Parametrised successor to the two-flop write-pointer synchroniser in the async FIFO.
- Carries a Gray-coded pointer from the write domain into the `rclk` domain through a configurable-depth flop chain.
- Adds a registered Gray-to-binary decode, a per-sample advance count (`delta`), an update strobe and a sticky step-violation flag.
- The read-side full/empty logic consumes the binary pointer and delta directly, so no Gray decode is needed downstream.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; pointer width `PW` = ADDR_WIDTH+1 (depth 2^ADDR_WIDTH).
- SYNC_STAGES, 2, number of synchroniser flops in the chain; legal range 2..4. Elaboration fails outside this range.
- MAX_STEP, 2^ADDR_WIDTH, largest legal binary advance between two consecutive synchronised samples.

Ports:
- rclk  input  1  read-domain clock; all flops on the rising edge.
- rrst  input  1  synchronous, active-high reset.
- wptr  input  PW  Gray-coded write pointer from the wclk domain; asynchronous to `rclk`.
- err_clr  input  1  synchronous clear of `rq_step_err`.
- rq_wptr_gray  output  PW  synchronised Gray pointer (last stage of the chain).
- rq_wptr_bin  output  PW  registered binary decode of `rq_wptr_gray`.
- rq_wptr_delta  output  PW  binary advance since the previous decoded sample, modulo 2^PW.
- rq_wptr_upd  output  1  one-cycle strobe, high when `rq_wptr_delta` != 0.
- rq_step_err  output  1  sticky; set when `rq_wptr_delta` > MAX_STEP.

Behaviour:
- Reset (`rrst`=1 at a `rclk` edge):
  - All chain flops, `rq_wptr_gray`, `rq_wptr_bin`, the previous-bin register, `rq_wptr_delta`, `rq_wptr_upd` and `rq_step_err` go to 0.
  - Reset dominates `err_clr` and all data movement.
  - Reset asserted mid-operation discards all in-flight samples. The first post-reset delta is computed against 0.
- Chain:
  - Stage[0] <= `wptr`; stage[i] <= stage[i-1].
  - `rq_wptr_gray` = stage[SYNC_STAGES-1].
  - Latency from a stable `wptr` to `rq_wptr_gray` is SYNC_STAGES `rclk` edges.
  - No logic is allowed between chain stages. Chain flops carry the synthesis async-register attribute.
- Decode stage (one extra cycle):
  - `rq_wptr_bin` <= gray2bin(`rq_wptr_gray`), where bin[PW-1] = g[PW-1] and bin[i] = bin[i+1] ^ g[i].
  - The previous-bin register holds the prior `rq_wptr_bin`.
  - `rq_wptr_delta` <= (gray2bin(`rq_wptr_gray`) - `rq_wptr_bin`) mod 2^PW, computed in the same cycle so delta aligns with the new bin value.
  - Total latency from `wptr` to `rq_wptr_bin`, `rq_wptr_delta` and `rq_wptr_upd` is SYNC_STAGES+1.
- Strobe:
  - `rq_wptr_upd` <= (delta != 0), registered and aligned with `rq_wptr_delta`.
  - It stays high on consecutive cycles if the pointer advances every sample.
- Wrap-around:
  - Pointer wraps from 2^PW-1 to 0. Delta uses modular subtraction, so the wrap reads as delta=1, not an error.
  - A fast writer can advance several counts between `rclk` samples. Delta then equals the full jump and `rq_wptr_upd` pulses once.
- Step error:
  - Flag state is held in a two-state FSM, OK and ERR.
  - OK -> ERR when the registered delta > MAX_STEP.
  - ERR -> OK on `err_clr`=1, unless a new violation occurs in the same cycle; set wins over clear.
  - `rq_step_err` = (state == ERR).
  - Backward motion appears as a delta near 2^PW and therefore flags as an error.
- Data path: no handshake; the output is free-running.

Test Plan:
- Reset then hold `wptr`=0 -> all outputs 0, `rq_wptr_upd` never asserts, `rq_step_err`=0.
- ADDR_WIDTH=4, SYNC_STAGES=2; step `wptr` 0 -> 5'b00001 at cycle 0 -> `rq_wptr_gray`=00001 at cycle 2; at cycle 3 `rq_wptr_bin`=1, `rq_wptr_delta`=1, `rq_wptr_upd`=1 for exactly one cycle.
- Jump `wptr` from Gray(3)=00010 to Gray(7)=00100 -> after 3 cycles `rq_wptr_bin`=7, `rq_wptr_delta`=4, single upd pulse, no error.
- Wrap `wptr` Gray(31)=10000 -> Gray(0)=00000 -> `rq_wptr_bin`=0, `rq_wptr_delta`=1, `rq_step_err`=0.
- Jump from bin 0 to Gray(20)=11110 -> `rq_wptr_delta`=20 > 16, so `rq_step_err` sets and stays set. `err_clr` clears it the next cycle. `err_clr` in the same cycle as a new violation leaves it set.
- Assert `rrst` for one cycle with Gray(9) in flight after SYNC_STAGES=3 rebuild -> all outputs 0 the next cycle. The post-reset sample of Gray(9) yields delta=9 and one upd pulse, at latency 4.

Source files
------------

// File: rtl/sync_ptr_r2_if.sv
// Bundle for the synchronised write-pointer path: raw Gray pointer and error clear in,
// decoded pointer, advance count, update strobe and step-violation flag out.
interface sync_ptr_r2_if #(
    parameter int PW = 5
);
    logic [PW-1:0] wptr;
    logic          err_clr;
    logic [PW-1:0] rq_wptr_gray;
    logic [PW-1:0] rq_wptr_bin;
    logic [PW-1:0] rq_wptr_delta;
    logic          rq_wptr_upd;
    logic          rq_step_err;

    modport master (
        output wptr,
        output err_clr,
        input  rq_wptr_gray,
        input  rq_wptr_bin,
        input  rq_wptr_delta,
        input  rq_wptr_upd,
        input  rq_step_err
    );

    modport slave (
        input  wptr,
        input  err_clr,
        output rq_wptr_gray,
        output rq_wptr_bin,
        output rq_wptr_delta,
        output rq_wptr_upd,
        output rq_step_err
    );
endinterface

// File: rtl/sync_ptr_r2.sv
// Write-pointer synchroniser into rclk: Gray flop chain, registered binary decode,
// per-sample advance count with update strobe, and a sticky step-violation flag.
module sync_ptr_r2 #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 2 ** ADDR_WIDTH
) (
    input  logic           rclk,
    input  logic           rrst,
    sync_ptr_r2_if.slave   bus
);
    localparam int PW = ADDR_WIDTH + 1;

    localparam logic [0:0] ST_OK  = 1'b0;
    localparam logic [0:0] ST_ERR = 1'b1;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("sync_ptr_r2: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pure flop-to-flop chain: no logic between stages so every stage can resolve metastability.
    (* ASYNC_REG = "TRUE" *) logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];

    logic [PW-1:0] bin_q,   bin_d;
    logic [PW-1:0] delta_q, delta_d;
    logic          upd_q,   upd_d;
    logic [0:0]    state_q, state_d;
    logic          step_viol;

    always_comb begin
        sync_d[0] = bus.wptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // bin_q doubles as the previous-sample register: delta is taken against it in the
    // same cycle the new decode is computed, so delta lands alongside the new bin.
    always_comb begin
        bin_d   = gray2bin(sync_q[SYNC_STAGES-1]);
        delta_d = bin_d - bin_q;
        upd_d   = (delta_d != '0);
    end

    assign step_viol = (32'(delta_q) > 32'(MAX_STEP));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK:  if (step_viol) state_d = ST_ERR;
            ST_ERR: if (bus.err_clr && !step_viol) state_d = ST_OK;
            default: state_d = ST_OK;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin_q   <= '0;
            delta_q <= '0;
            upd_q   <= 1'b0;
            state_q <= ST_OK;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            bin_q   <= bin_d;
            delta_q <= delta_d;
            upd_q   <= upd_d;
            state_q <= state_d;
        end
    end

    assign bus.rq_wptr_gray  = sync_q[SYNC_STAGES-1];
    assign bus.rq_wptr_bin   = bin_q;
    assign bus.rq_wptr_delta = delta_q;
    assign bus.rq_wptr_upd   = upd_q;
    assign bus.rq_step_err   = (state_q == ST_ERR);
endmodule

// File: tb/tb_sync_ptr_r2.sv
// Bench for sync_ptr_r2: directed vector table (2 stages), reset-in-flight sequence
// (3 stages), then random pointer motion checked against a latency-based model.
module tb_sync_ptr_r2;
    localparam int NR = 400;

    logic clk = 1'b0;
    logic rst2, rst3;
    always #5 clk = ~clk;

    sync_ptr_r2_if #(.PW(5)) if2 ();
    sync_ptr_r2_if #(.PW(5)) if3 ();

    sync_ptr_r2 #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut2 (.rclk(clk), .rrst(rst2), .bus(if2.slave));
    sync_ptr_r2 #(.ADDR_WIDTH(4), .SYNC_STAGES(3)) dut3 (.rclk(clk), .rrst(rst3), .bus(if3.slave));

    typedef struct {
        logic       rst;
        logic [4:0] w;
        logic       clr;
        logic [4:0] g, b, d;
        logic       u, e;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model history for the random phase
    logic [4:0] hv   [NR];
    logic       hclr [NR];
    logic       herr [2][NR];
    int         r;

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic [4:0] w, input logic clr,
                       input logic [4:0] g, input logic [4:0] b, input logic [4:0] d,
                       input logic u, input logic e);
        vec_t v;
        v.rst = rst; v.w = w; v.clr = clr; v.g = g; v.b = b; v.d = d; v.u = u; v.e = e;
        tbl.push_back(v);
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Gray output after edge n is the value driven s-1 edges earlier, if that was after the last reset.
    function automatic logic [4:0] m_gray(input int s, input int n);
        if (n - s + 1 > r) return hv[n-s+1];
        return 5'd0;
    endfunction

    function automatic logic [4:0] m_bin(input int s, input int n);
        if (n > r) return g2b(m_gray(s, n - 1));
        return 5'd0;
    endfunction

    function automatic logic [4:0] m_delta(input int s, input int n);
        if (n > r) return m_bin(s, n) - m_bin(s, n - 1);
        return 5'd0;
    endfunction

    task automatic drive(input logic rs2, input logic rs3, input logic [4:0] w, input logic clr);
        @(negedge clk);
        rst2 = rs2; rst3 = rs3;
        if2.wptr = w; if2.err_clr = clr;
        if3.wptr = w; if3.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] cnt;
        logic [4:0] eg, eb, ed;
        logic       ee;
        rst2 = 1'b1; rst3 = 1'b1;
        if2.wptr = '0; if2.err_clr = 1'b0;
        if3.wptr = '0; if3.err_clr = 1'b0;

        // rst, w, clr | gray, bin, delta, upd, err   (2-stage DUT)
        row(1, 0, 0,   0, 0, 0, 0, 0);
        row(0, 0, 0,   0, 0, 0, 0, 0);
        row(0, 0, 0,   0, 0, 0, 0, 0);
        row(0, 1, 0,   0, 0, 0, 0, 0);
        row(0, 1, 0,   1, 0, 0, 0, 0);
        row(0, 1, 0,   1, 1, 1, 1, 0);
        row(0, 1, 0,   1, 1, 0, 0, 0);
        row(0, 2, 0,   1, 1, 0, 0, 0);
        row(0, 2, 0,   2, 1, 0, 0, 0);
        row(0, 2, 0,   2, 3, 2, 1, 0);
        row(0, 4, 0,   2, 3, 0, 0, 0);
        row(0, 4, 0,   4, 3, 0, 0, 0);
        row(0, 4, 0,   4, 7, 4, 1, 0);
        row(0, 4, 0,   4, 7, 0, 0, 0);
        row(0, 28, 0,  4, 7, 0, 0, 0);
        row(0, 28, 0, 28, 7, 0, 0, 0);
        row(0, 28, 0, 28, 23, 16, 1, 0);
        row(0, 16, 0, 28, 23, 0, 0, 0);
        row(0, 16, 0, 16, 23, 0, 0, 0);
        row(0, 16, 0, 16, 31, 8, 1, 0);
        row(0, 0, 0,  16, 31, 0, 0, 0);
        row(0, 0, 0,   0, 31, 0, 0, 0);
        row(0, 0, 0,   0, 0, 1, 1, 0);
        row(0, 0, 0,   0, 0, 0, 0, 0);
        row(0, 30, 0,  0, 0, 0, 0, 0);
        row(0, 30, 0, 30, 0, 0, 0, 0);
        row(0, 30, 0, 30, 20, 20, 1, 0);
        row(0, 30, 0, 30, 20, 0, 0, 1);
        row(0, 30, 0, 30, 20, 0, 0, 1);
        row(0, 30, 1, 30, 20, 0, 0, 0);
        row(0, 30, 0, 30, 20, 0, 0, 0);
        row(0, 12, 0, 30, 20, 0, 0, 0);
        row(0, 12, 0, 12, 20, 0, 0, 0);
        row(0, 12, 0, 12, 8, 20, 1, 0);
        row(0, 12, 1, 12, 8, 0, 0, 1);
        row(0, 12, 0, 12, 8, 0, 0, 1);
        row(0, 12, 1, 12, 8, 0, 0, 0);
        row(1, 12, 0,  0, 0, 0, 0, 0);
        row(0, 12, 0,  0, 0, 0, 0, 0);
        row(0, 12, 0, 12, 0, 0, 0, 0);
        row(0, 12, 0, 12, 8, 8, 1, 0);
        row(0, 12, 0, 12, 8, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, 1'b1, tbl[i].w, tbl[i].clr);
            chk($sformatf("dir[%0d].gray", i),  if2.rq_wptr_gray,  tbl[i].g);
            chk($sformatf("dir[%0d].bin", i),   if2.rq_wptr_bin,   tbl[i].b);
            chk($sformatf("dir[%0d].delta", i), if2.rq_wptr_delta, tbl[i].d);
            chk($sformatf("dir[%0d].upd", i),   5'(if2.rq_wptr_upd), 5'(tbl[i].u));
            chk($sformatf("dir[%0d].err", i),   5'(if2.rq_step_err), 5'(tbl[i].e));
        end

        // 3-stage DUT: settle on bin 2, put Gray(9) in flight, then reset over it
        drive(1'b1, 1'b1, 5'd3, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 5'd3, 1'b0);
        chk("s3.pre_bin", if3.rq_wptr_bin, 5'd2);
        drive(1'b1, 1'b0, 5'd13, 1'b0);
        drive(1'b1, 1'b1, 5'd13, 1'b0);
        chk("s3.rst_gray",  if3.rq_wptr_gray,  5'd0);
        chk("s3.rst_bin",   if3.rq_wptr_bin,   5'd0);
        chk("s3.rst_delta", if3.rq_wptr_delta, 5'd0);
        chk("s3.rst_upd",   5'(if3.rq_wptr_upd), 5'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b0, 5'd13, 1'b0);
            chk($sformatf("s3.post%0d.gray", k),  if3.rq_wptr_gray,  (k >= 3) ? 5'd13 : 5'd0);
            chk($sformatf("s3.post%0d.bin", k),   if3.rq_wptr_bin,   (k >= 4) ? 5'd9 : 5'd0);
            chk($sformatf("s3.post%0d.delta", k), if3.rq_wptr_delta, (k == 4) ? 5'd9 : 5'd0);
            chk($sformatf("s3.post%0d.upd", k),   5'(if3.rq_wptr_upd), (k == 4) ? 5'd1 : 5'd0);
        end

        // Random pointer motion, both DUTs driven alike
        cnt = '0;
        r   = 0;
        for (int n = 0; n < NR; n++) begin
            int   k;
            logic rs;
            rs = (n == 0) || ($urandom_range(0, 59) == 0);
            if (rs) r = n;
            k = $urandom_range(0, 9);
            if (k < 5)       cnt = cnt;
            else if (k < 8)  cnt = cnt + 5'($urandom_range(1, 3));
            else if (k == 8) cnt = cnt + 5'($urandom_range(0, 31));
            else             cnt = cnt + 5'($urandom_range(16, 17));
            hv[n]   = cnt ^ (cnt >> 1);
            hclr[n] = ($urandom_range(0, 7) == 0);
            drive(rs, rs, hv[n], hclr[n]);
            for (int si = 0; si < 2; si++) begin
                if (n == r) ee = 1'b0;
                else        ee = (m_delta(si + 2, n - 1) > 5'd16) || (herr[si][n-1] && !hclr[n]);
                herr[si][n] = ee;
                eg = m_gray(si + 2, n);
                eb = m_bin(si + 2, n);
                ed = m_delta(si + 2, n);
                if (si == 0) begin
                    chk($sformatf("rnd2[%0d].gray", n),  if2.rq_wptr_gray,  eg);
                    chk($sformatf("rnd2[%0d].bin", n),   if2.rq_wptr_bin,   eb);
                    chk($sformatf("rnd2[%0d].delta", n), if2.rq_wptr_delta, ed);
                    chk($sformatf("rnd2[%0d].upd", n),   5'(if2.rq_wptr_upd), 5'(ed != 0));
                    chk($sformatf("rnd2[%0d].err", n),   5'(if2.rq_step_err), 5'(ee));
                end else begin
                    chk($sformatf("rnd3[%0d].gray", n),  if3.rq_wptr_gray,  eg);
                    chk($sformatf("rnd3[%0d].bin", n),   if3.rq_wptr_bin,   eb);
                    chk($sformatf("rnd3[%0d].delta", n), if3.rq_wptr_delta, ed);
                    chk($sformatf("rnd3[%0d].upd", n),   5'(if3.rq_wptr_upd), 5'(ed != 0));
                    chk($sformatf("rnd3[%0d].err", n),   5'(if3.rq_step_err), 5'(ee));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
